// File: rtl/serial_latch_pkg.sv
// rtl/serial_latch_pkg.sv - shared state encoding, defaults and sizing helper for serial_latch_loader
// Contents:
//   state_t                           : 3-bit FSM encoding (ST_IDLE..ST_DONE)
//   DEFAULT_WIDTH, DEFAULT_GATE_CYCLES: default parameter values for the loader and benches
//   counter_width()                   : bits needed to hold a counter load value (minimum 1)
package serial_latch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_SETUP = 3'd2,
        ST_GATE  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_GATE_CYCLES = 2;

    // A load value of 0 still needs one bit of counter storage.
    function automatic int counter_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// rtl/cycle_down_counter.sv - loadable synchronous-reset down-counter with zero flag
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the count
//   load       : load load_value (has priority over dec)
//   load_value : value loaded when load is high
//   dec        : decrement by one; saturates at zero so the count never wraps
//   zero       : high while the count is zero
module cycle_down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/serial_latch_loader.sv
// rtl/serial_latch_loader.sv - shifts in a serial word and drives a gated D latch bank with setup/hold framing
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   start : begin a load; only honoured in IDLE
//   sdi   : serial data, MSB first, sampled during SHIFT
//   D     : registered parallel data to the latch bank
//   G     : registered latch gate
//   busy  : registered, high for the whole load
//   done  : registered one-cycle completion pulse
module serial_latch_loader
    import serial_latch_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdi,
    output logic [WIDTH-1:0] D,
    output logic             G,
    output logic             busy,
    output logic             done
);

    localparam int BIT_CW  = counter_width(WIDTH - 1);
    localparam int GATE_CW = counter_width(GATE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] d_next;
    logic             g_next;
    logic             busy_next;
    logic             done_next;

    logic bit_load;
    logic bit_dec;
    logic bit_zero;
    logic gate_load;
    logic gate_dec;
    logic gate_zero;

    // Counts the samples still to come after the current one; zero means the
    // word is complete after this edge.
    cycle_down_counter #(.CW(BIT_CW)) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (bit_load),
        .load_value (BIT_CW'(WIDTH - 1)),
        .dec        (bit_dec),
        .zero       (bit_zero)
    );

    // Loaded one cycle before G rises; the rising edge itself does not count
    // down, so G sees exactly GATE_CYCLES high cycles.
    cycle_down_counter #(.CW(GATE_CW)) u_gate_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (gate_load),
        .load_value (GATE_CW'(GATE_CYCLES - 1)),
        .dec        (gate_dec),
        .zero       (gate_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            D     <= '0;
            G     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            D     <= d_next;
            G     <= g_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        d_next     = D;
        g_next     = G;
        busy_next  = busy;
        done_next  = 1'b0;
        bit_load   = 1'b0;
        bit_dec    = 1'b0;
        gate_load  = 1'b0;
        gate_dec   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SHIFT;
                    busy_next  = 1'b1;
                    bit_load   = 1'b1;
                end
            end

            ST_SHIFT: begin
                // Shift left so the first sampled bit ends in the MSB.
                shreg_next = (shreg << 1) | WIDTH'(sdi);
                if (bit_zero) begin
                    state_next = ST_SETUP;
                end else begin
                    bit_dec = 1'b1;
                end
            end

            ST_SETUP: begin
                // D moves here only; G stays low one more cycle for setup.
                d_next     = shreg;
                gate_load  = 1'b1;
                state_next = ST_GATE;
            end

            ST_GATE: begin
                // G low on entry marks the rising edge; D is already stable.
                if (!G) begin
                    g_next = 1'b1;
                end else if (gate_zero) begin
                    g_next     = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    gate_dec = 1'b1;
                end
            end

            ST_DONE: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                g_next     = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_latch_loader.sv
// tb/tb_serial_latch_loader.sv - randomized self-checking bench for serial_latch_loader driving a gated D latch
module tb_serial_latch_loader;
    import serial_latch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Unit 0: WIDTH=8, GATE_CYCLES=2. Unit 1: WIDTH=1, GATE_CYCLES=1.
    logic       rst8, start8, sdi8;
    logic [7:0] d8;
    logic       g8, busy8, done8;
    logic       rst1, start1, sdi1;
    logic [0:0] d1;
    logic       g1, busy1, done1;

    serial_latch_loader #(.WIDTH(8), .GATE_CYCLES(2)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sdi(sdi8),
        .D(d8), .G(g8), .busy(busy8), .done(done8)
    );

    serial_latch_loader #(.WIDTH(1), .GATE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .sdi(sdi1),
        .D(d1), .G(g1), .busy(busy1), .done(done1)
    );

    // Gated D latch on bit 0 of the wide unit.
    logic q8 = 1'b0;
    logic p8;
    always @(g8 or d8) if (g8) q8 = d8[0];
    assign p8 = ~q8;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Timeline model: a load started at edge ls has every output fixed by its
    // offset from ls.
    int         ls  [2] = '{-1, -1};
    int         rel [2] = '{-1, -1};
    logic [7:0] word[2] = '{8'd0, 8'd0};
    logic [7:0] ed  [2] = '{8'd0, 8'd0};
    logic       eq8 = 1'b0;

    function automatic int wd(input int u);
        return (u == 0) ? 8 : 1;
    endfunction

    function automatic int gc(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    // {G, busy, done}
    function automatic logic [2:0] exp_ctl(input int u);
        int r = rel[u];
        int w = wd(u);
        int g = gc(u);
        return {(r >= w + 2 && r <= w + 1 + g), (r >= 0 && r <= w + g + 2), (r == w + g + 2)};
    endfunction

    task automatic model_edge(input int u, input logic st, input logic sd, input logic rs);
        int w = wd(u);
        int g = gc(u);
        if (rs) begin
            ls[u]  = -1;
            rel[u] = -1;
            ed[u]  = 8'd0;
        end else begin
            if ((ls[u] < 0 || cyc >= ls[u] + w + g + 4) && st) ls[u] = cyc;
            if (ls[u] >= 0) begin
                rel[u] = cyc - ls[u];
                if (rel[u] >= 1 && rel[u] <= w) word[u] = {word[u][6:0], sd};
                if (rel[u] == w + 1) ed[u] = word[u] & 8'((1 << w) - 1);
            end else begin
                rel[u] = -1;
            end
        end
    endtask

    task automatic tick(input logic st8, input logic sd8, input logic rs8,
                        input logic st1, input logic sd1, input logic rs1);
        start8 = st8; sdi8 = sd8; rst8 = rs8;
        start1 = st1; sdi1 = sd1; rst1 = rs1;
        @(posedge clk);
        model_edge(0, st8, sd8, rs8);
        model_edge(1, st1, sd1, rs1);
        cyc++;
        #1;
        if (exp_ctl(0) & 3'b100) eq8 = ed[0][0];
    endtask

    task automatic tick8(input logic st, input logic sd, input logic rs);
        tick(st, sd, rs, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 1'b0, (i < 2), 1'b0, 1'b0, (i < 2));
            tests++;
            if ({d8, g8, busy8, done8} !== 11'd0) begin
                fails++;
                $display("FAIL reset_w8 cyc=%0d got=%h exp=0", i, {d8, g8, busy8, done8});
            end
            tests++;
            if ({d1, g1, busy1, done1} !== 4'd0) begin
                fails++;
                $display("FAIL reset_w1 cyc=%0d got=%h exp=0", i, {d1, g1, busy1, done1});
            end
        end
    endtask

    task automatic test_basic;
        logic [7:0] bits = 8'b1011_0010;
        int busy_n = 0;
        int done_n = 0;
        for (int e = 0; e < 15; e++) begin
            tick8(e == 0, (e >= 1 && e <= 8) ? bits[8 - e] : 1'b0, 1'b0);
            tests++;
            if ({d8, g8, busy8, done8} !== {ed[0], exp_ctl(0)}) begin
                fails++;
                $display("FAIL basic_outputs edge=%0d got=%h exp=%h", e, {d8, g8, busy8, done8}, {ed[0], exp_ctl(0)});
            end
            if (e == 9) begin
                tests++;
                if (d8 !== 8'hB2) begin
                    fails++;
                    $display("FAIL basic_d edge=9 got=%h exp=b2", d8);
                end
            end
            busy_n += busy8;
            done_n += done8;
        end
        tests++;
        if (busy_n != 13 || done_n != 1) begin
            fails++;
            $display("FAIL basic_counts got busy=%0d done=%0d exp busy=13 done=1", busy_n, done_n);
        end
        tests++;
        if (q8 !== 1'b0 || p8 !== 1'b1) begin
            fails++;
            $display("FAIL basic_latch got q=%b p=%b exp q=0 p=1", q8, p8);
        end
    endtask

    task automatic test_stability;
        logic [7:0] pd;
        logic       pg;
        for (int n = 0; n < 4; n++) begin
            for (int e = 0; e < 14; e++) begin
                pd = d8;
                pg = g8;
                tick8(e == 0, 1'($urandom()), 1'b0);
                tests++;
                if ({d8, g8, busy8, done8} !== {ed[0], exp_ctl(0)}) begin
                    fails++;
                    $display("FAIL stab_outputs load=%0d edge=%0d got=%h exp=%h", n, e, {d8, g8, busy8, done8}, {ed[0], exp_ctl(0)});
                end
                tests++;
                if (d8 !== pd && (g8 || pg)) begin
                    fails++;
                    $display("FAIL stab_hold load=%0d edge=%0d got d=%h exp d=%h", n, e, d8, pd);
                end
                tests++;
                if (q8 !== eq8 || p8 !== ~eq8) begin
                    fails++;
                    $display("FAIL stab_latch load=%0d edge=%0d got q=%b exp q=%b", n, e, q8, eq8);
                end
            end
        end
    endtask

    task automatic test_ignored_start;
        int done_n = 0;
        for (int e = 0; e < 28; e++) begin
            tick8(1'b1, 1'($urandom()), 1'b0);
            tests++;
            if ({d8, g8, busy8, done8} !== {ed[0], exp_ctl(0)}) begin
                fails++;
                $display("FAIL ign_outputs edge=%0d got=%h exp=%h", e, {d8, g8, busy8, done8}, {ed[0], exp_ctl(0)});
            end
            if (e == 13 || e == 14) begin
                tests++;
                if (busy8 !== (e == 14)) begin
                    fails++;
                    $display("FAIL ign_restart edge=%0d got busy=%b exp busy=%b", e, busy8, (e == 14));
                end
            end
            done_n += done8;
        end
        tests++;
        if (done_n != 2) begin
            fails++;
            $display("FAIL ign_done_count got=%0d exp=2", done_n);
        end
    endtask

    task automatic test_reset_mid_gate;
        logic [7:0] w = 8'd0;
        logic       b;
        for (int e = 0; e < 12; e++) begin
            b = 1'($urandom());
            tick8(e == 0, b, e == 11);
            if (e == 10) begin
                tests++;
                if (g8 !== 1'b1) begin
                    fails++;
                    $display("FAIL rmg_gate_open got G=%b exp G=1", g8);
                end
            end
        end
        tests++;
        if ({d8, g8, busy8, done8} !== 11'd0) begin
            fails++;
            $display("FAIL rmg_after_reset got=%h exp=0", {d8, g8, busy8, done8});
        end
        for (int e = 0; e < 4; e++) begin
            tick8(1'b0, 1'($urandom()), 1'b0);
            tests++;
            if ({d8, g8, busy8, done8} !== 11'd0) begin
                fails++;
                $display("FAIL rmg_idle edge=%0d got=%h exp=0", e, {d8, g8, busy8, done8});
            end
        end
        for (int e = 0; e < 14; e++) begin
            b = 1'($urandom());
            if (e >= 1 && e <= 8) w = {w[6:0], b};
            tick8(e == 0, b, 1'b0);
            tests++;
            if ({d8, g8, busy8, done8} !== {ed[0], exp_ctl(0)}) begin
                fails++;
                $display("FAIL rmg_reload edge=%0d got=%h exp=%h", e, {d8, g8, busy8, done8}, {ed[0], exp_ctl(0)});
            end
        end
        tests++;
        if (d8 !== w) begin
            fails++;
            $display("FAIL rmg_word got=%h exp=%h", d8, w);
        end
    endtask

    task automatic test_corner;
        int busy_n;
        for (int n = 0; n < 3; n++) begin
            logic b = (n == 0) ? 1'b1 : 1'($urandom());
            busy_n = 0;
            for (int e = 0; e < 6; e++) begin
                tick(1'b0, 1'b0, 1'b0, e == 0, (e == 1) ? b : 1'($urandom()), 1'b0);
                tests++;
                if ({d1, g1, busy1, done1} !== {ed[1][0], exp_ctl(1)}) begin
                    fails++;
                    $display("FAIL corner_outputs load=%0d edge=%0d got=%h exp=%h", n, e, {d1, g1, busy1, done1}, {ed[1][0], exp_ctl(1)});
                end
                tests++;
                if (g1 !== (e == 3) || done1 !== (e == 4)) begin
                    fails++;
                    $display("FAIL corner_timing load=%0d edge=%0d got G=%b done=%b", n, e, g1, done1);
                end
                if (e == 2) begin
                    tests++;
                    if (d1 !== b) begin
                        fails++;
                        $display("FAIL corner_d load=%0d got=%b exp=%b", n, d1, b);
                    end
                end
                busy_n += busy1;
            end
            tests++;
            if (busy_n != 5) begin
                fails++;
                $display("FAIL corner_busy load=%0d got=%0d exp=5", n, busy_n);
            end
        end
    endtask

    initial begin
        rst8 = 1'b1; start8 = 1'b0; sdi8 = 1'b0;
        rst1 = 1'b1; start1 = 1'b0; sdi1 = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_stability();
        test_ignored_start();
        test_reset_mid_gate();
        test_corner();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_latch_loader.md
Name: serial_latch_loader

Overview:
Clocked upstream stage that drives a gated D latch bank. It shifts in a WIDTH-bit serial word, presents it on a stable parallel D bus, then opens the latch gate G for a fixed number of cycles. It guarantees one cycle of D setup before G rises and holds D unchanged while G is high and after it falls. A single start/busy/done handshake frames each load.

Parameters:
WIDTH, 8, serial word length and width of the D bus; legal range 1 or more.
GATE_CYCLES, 2, number of clock cycles G stays high per load; legal range 1 or more.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin a load; sampled only in IDLE.
sdi  input  1  serial data, MSB first, one bit per cycle during SHIFT.
D  output  WIDTH  parallel data to the latch bank; registered.
G  output  1  latch gate (transparent while high); registered.
busy  output  1  high while a load is in progress; registered.
done  output  1  one-cycle completion pulse; registered.

Behaviour:
- Reset (rst high at a clk edge): state goes to IDLE. D=0, G=0, busy=0, done=0. Shift register and counter are cleared.
- Reset mid-operation: the same values apply at the next edge. G drops immediately with no done pulse, and the partial word is discarded.
- States: IDLE, SHIFT, SETUP, GATE, DONE. All outputs are registered, with no combinational paths from inputs to outputs.
- IDLE:
  - start=1 at edge k moves the state to SHIFT and sets busy=1.
  - start=0 keeps the state in IDLE.
  - D holds its last loaded value.
- SHIFT:
  - sdi is sampled at edges k+1 through k+WIDTH into the shift register, MSB first (first sampled bit ends up in bit WIDTH-1).
  - A bit counter tracks the samples. After the WIDTH-th sample the state moves to SETUP.
  - D does not change during SHIFT.
- SETUP:
  - At edge k+WIDTH+1, D is loaded from the shift register and the state moves to GATE.
  - G is still 0 in this cycle, which provides one full cycle of D setup.
- GATE:
  - At edge k+WIDTH+2, G is set to 1.
  - G stays high for exactly GATE_CYCLES cycles, timed by a down-counter.
  - At edge k+WIDTH+2+GATE_CYCLES, G is set to 0, done is set to 1, and the state moves to DONE.
- DONE:
  - At the next edge, done is set to 0, busy is set to 0, and the state moves to IDLE.
  - busy is therefore high for exactly WIDTH+GATE_CYCLES+3 cycles per load.
- D stability:
  - D changes only at the SETUP edge or at reset.
  - D never changes in any cycle where G=1, or in the cycle in which G falls (hold margin for the latch).
- start handling:
  - start while busy=1, including the DONE cycle, is ignored. No queuing.
  - start must be low for at least one sampled IDLE edge, otherwise a new load begins. Back-to-back loads are legal, so the minimum load period is WIDTH+GATE_CYCLES+4 cycles.
- sdi is don't-care outside SHIFT.
- Counter widths are sized with $clog2 to cover WIDTH and GATE_CYCLES. Counters never wrap mid-state.

Decomposition:
- Shared package (serial_latch_pkg): state encoding constants ST_IDLE, ST_SHIFT, ST_SETUP, ST_GATE, ST_DONE (3-bit), plus default WIDTH/GATE_CYCLES values for benches.
- One natural sub-module, cycle_down_counter: loadable, synchronous-reset down-counter with a zero flag. It is instanced twice, once as the bit counter and once as the gate timer.
- The top level holds the FSM, the shift register and the D register.
- The bench instances serial_latch_loader feeding the existing gated_d_latch (G to G, one D bit to D) and checks the latch outputs P/Q.

Test Plan:
1. Reset behaviour: rst=1 for 2 cycles, then 0 with start=0 for 5 cycles -> D=0x00, G=0, busy=0, done=0 throughout.
2. Basic load (WIDTH=8, GATE_CYCLES=2): start=1 at edge 0; sdi=1,0,1,1,0,0,1,0 at edges 1–8 -> checks:
   - D=0xB2 after edge 9.
   - G=1 after edges 10 and 11, G=0 after edge 12.
   - done=1 only after edge 12.
   - busy=1 from edge 0 up to edge 13 (13 cycles).
   - Latch Q=D[0]=0.
3. D stability: same run with sdi toggling randomly outside SHIFT -> D is constant from edge 9 until the next SETUP edge, and never changes while G=1.
4. Ignored start: hold start=1 continuously from edge 0 -> second load begins at edge 14 (first IDLE edge), not earlier; no extra done pulses.
5. Reset mid-gate: assert rst at edge 11 (G=1) -> after edge 11, G=0, D=0x00, busy=0, and no done pulse; next start begins a clean load.
6. Parameter corner (WIDTH=1, GATE_CYCLES=1): start at edge 0, sdi=1 at edge 1 -> checks:
   - D=0x1 after edge 2.
   - G high for one cycle after edge 3.
   - done after edge 4; busy lasts 5 cycles.
